// File: rtl/wb_stage_trace_pkg.sv
// Shared types and constants for the LA32R write-back stage and its trace FIFO.
package wb_stage_trace_pkg;
  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 5;
  localparam int PC_W_DEF        = 32;
  localparam int WE_W_DEF        = 4;
  localparam int TRACE_DEPTH_DEF = 4;
  localparam int CNT_W_DEF       = 32;

  localparam int RF_ZERO_IDX = 0;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [WE_W_DEF-1:0]   we;
    logic [ADDR_W_DEF-1:0] wnum;
    logic [DATA_W_DEF-1:0] wdata;
  } wb_trace_t;
endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO for retired-instruction trace entries; head reads 0 when empty.
module wb_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      w_one;

  assign w_one = {{AW{1'b0}}, 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + w_one;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + w_one;
    end
  end

  // Storage is not reset; the empty gate on o_head hides stale contents.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/wb_stage_trace.sv
// LA32R write-back stage: single-commit RF write, ID bypass and retire trace FIFO.
module wb_stage_trace
  import wb_stage_trace_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int PC_W        = PC_W_DEF,
  parameter int WE_W        = WE_W_DEF,
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              to_wb_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [WE_W-1:0]   in_rf_we,
  input  logic [ADDR_W-1:0] in_rf_waddr,
  input  logic [DATA_W-1:0] in_rf_wdata,
  output logic              wb_allow_in,
  output logic              wb_ready_go,
  output logic [WE_W-1:0]   rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              debug_valid,
  input  logic              debug_ready,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [WE_W-1:0]   debug_wb_rf_we,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic [CNT_W-1:0]  retire_cnt
);
  localparam int TW = PC_W + WE_W + ADDR_W + DATA_W;

  logic              r_wb_valid;
  logic [PC_W-1:0]   r_pc;
  logic [WE_W-1:0]   r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_commit;
  logic [WE_W-1:0]   w_eff_we;
  logic [TW-1:0]     w_head;

  // A full FIFO only blocks retirement when the sink is not popping this cycle.
  assign wb_ready_go = !w_fifo_full || debug_ready;
  assign wb_allow_in = !r_wb_valid || wb_ready_go;
  assign w_commit    = r_wb_valid && wb_ready_go;
  assign w_eff_we    = (r_waddr == ADDR_W'(RF_ZERO_IDX)) ? '0 : r_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wb_valid <= 1'b0;
      r_pc       <= '0;
      r_we       <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else if (wb_allow_in) begin
      r_wb_valid <= to_wb_valid;
      if (to_wb_valid) begin
        r_pc    <= in_pc;
        r_we    <= in_rf_we;
        r_waddr <= in_rf_waddr;
        r_wdata <= in_rf_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_retire_cnt <= '0;
    else if (w_commit) r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign rf_we      = w_commit ? w_eff_we : '0;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign fwd_valid  = r_wb_valid && (|w_eff_we);
  assign fwd_waddr  = r_waddr;
  assign fwd_wdata  = r_wdata;
  assign retire_cnt = r_retire_cnt;

  assign debug_valid = !w_fifo_empty;
  assign w_pop       = debug_valid && debug_ready;

  wb_trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_push  (w_commit),
    .i_pop   (w_pop),
    .i_din   ({r_pc, w_eff_we, r_waddr, r_wdata}),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head)
  );

  assign {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} = w_head;
endmodule

// File: tb/tb_wb_stage_trace.sv
// Directed bench for wb_stage_trace: commit timing, r0 handling, stalls, FIFO wrap, async reset.
module tb_wb_stage_trace;
  logic        clk;
  logic        resetn;
  logic        to_wb_valid;
  logic [31:0] in_pc;
  logic [3:0]  in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic [31:0] in_rf_wdata;
  logic        wb_allow_in;
  logic        wb_ready_go;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        debug_valid;
  logic        debug_ready;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  wb_stage_trace dut (
    .clk               (clk),
    .resetn            (resetn),
    .to_wb_valid       (to_wb_valid),
    .in_pc             (in_pc),
    .in_rf_we          (in_rf_we),
    .in_rf_waddr       (in_rf_waddr),
    .in_rf_wdata       (in_rf_wdata),
    .wb_allow_in       (wb_allow_in),
    .wb_ready_go       (wb_ready_go),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_valid         (fwd_valid),
    .fwd_waddr         (fwd_waddr),
    .fwd_wdata         (fwd_wdata),
    .debug_valid       (debug_valid),
    .debug_ready       (debug_ready),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retire_cnt        (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [3:0] we,
                     input logic [4:0] wa, input logic [31:0] wd);
    to_wb_valid = v;
    in_pc       = pc;
    in_rf_we    = we;
    in_rf_waddr = wa;
    in_rf_wdata = wd;
  endtask

  initial begin
    resetn      = 1'b0;
    debug_ready = 1'b1;
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #3;
    chk("rst_allow_in",  32'(wb_allow_in), 32'd1);
    chk("rst_ready_go",  32'(wb_ready_go), 32'd1);
    chk("rst_rf_we",     32'(rf_we), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_dbg_valid", 32'(debug_valid), 32'd0);
    chk("rst_dbg_pc",    debug_wb_pc, 32'd0);
    chk("rst_retire",    retire_cnt, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // three back-to-back instructions, sink always ready
    drv(1'b1, 32'h1c000000, 4'hF, 5'd1, 32'h11);
    #1 chk("b2b_c0_rf_we", 32'(rf_we), 32'd0);
    tick();
    drv(1'b1, 32'h1c000004, 4'hF, 5'd2, 32'h22);
    #1 chk("b2b_c1_rf_we", 32'(rf_we), 32'hF);
    chk("b2b_c1_waddr",  32'(rf_waddr), 32'd1);
    chk("b2b_c1_wdata",  rf_wdata, 32'h11);
    chk("b2b_c1_fwd",    32'(fwd_valid), 32'd1);
    chk("b2b_c1_dbgv",   32'(debug_valid), 32'd0);
    tick();
    drv(1'b1, 32'h1c000008, 4'hF, 5'd3, 32'h33);
    #1 chk("b2b_c2_rf_we", 32'(rf_we), 32'hF);
    chk("b2b_c2_waddr",  32'(rf_waddr), 32'd2);
    chk("b2b_c2_head",   debug_wb_pc, 32'h1c000000);
    tick();
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #1 chk("b2b_c3_rf_we", 32'(rf_we), 32'hF);
    chk("b2b_c3_waddr",  32'(rf_waddr), 32'd3);
    chk("b2b_c3_head",   debug_wb_pc, 32'h1c000004);
    chk("b2b_c3_retire", retire_cnt, 32'd2);
    tick();
    #1 chk("b2b_c4_rf_we", 32'(rf_we), 32'd0);
    chk("b2b_c4_head",   debug_wb_pc, 32'h1c000008);
    chk("b2b_c4_wnum",   32'(debug_wb_rf_wnum), 32'd3);
    chk("b2b_c4_retire", retire_cnt, 32'd3);
    tick();
    chk("b2b_c5_dbgv",   32'(debug_valid), 32'd0);

    // write to r0 must be suppressed but still traced
    drv(1'b1, 32'h1c00000c, 4'hF, 5'd0, 32'hDEADBEEF);
    tick();
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #1 chk("r0_rf_we",   32'(rf_we), 32'd0);
    chk("r0_fwd_valid",  32'(fwd_valid), 32'd0);
    chk("r0_ready_go",   32'(wb_ready_go), 32'd1);
    tick();
    chk("r0_head_pc",    debug_wb_pc, 32'h1c00000c);
    chk("r0_head_we",    32'(debug_wb_rf_we), 32'd0);
    chk("r0_head_wnum",  32'(debug_wb_rf_wnum), 32'd0);
    chk("r0_head_wdata", debug_wb_rf_wdata, 32'hDEADBEEF);
    chk("r0_retire",     retire_cnt, 32'd4);
    tick();

    // bubble between two instructions
    drv(1'b1, 32'h100, 4'hF, 5'd5, 32'h55);
    tick();
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #1 chk("bub_c1_rf_we", 32'(rf_we), 32'hF);
    chk("bub_c1_waddr",  32'(rf_waddr), 32'd5);
    tick();
    drv(1'b1, 32'h104, 4'hF, 5'd6, 32'h66);
    #1 chk("bub_c2_rf_we", 32'(rf_we), 32'd0);
    chk("bub_c2_fwd",    32'(fwd_valid), 32'd0);
    chk("bub_c2_head",   debug_wb_pc, 32'h100);
    chk("bub_c2_retire", retire_cnt, 32'd5);
    tick();
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #1 chk("bub_c3_rf_we", 32'(rf_we), 32'hF);
    chk("bub_c3_waddr",  32'(rf_waddr), 32'd6);
    chk("bub_c3_dbgv",   32'(debug_valid), 32'd0);
    chk("bub_c3_retire", retire_cnt, 32'd5);
    tick();
    chk("bub_c4_rf_we",  32'(rf_we), 32'd0);
    chk("bub_c4_head",   debug_wb_pc, 32'h104);
    chk("bub_c4_retire", retire_cnt, 32'd6);
    tick();

    // sink stalled: four commits fill the FIFO, fifth holds in WB
    debug_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, 32'h200 + 32'(4 * k), 4'hF, 5'(k + 1), 32'hA0 + 32'(k));
      tick();
    end
    drv(1'b1, 32'h214, 4'hF, 5'd6, 32'hA5);
    #1 chk("stl_ready_go", 32'(wb_ready_go), 32'd0);
    chk("stl_allow_in",  32'(wb_allow_in), 32'd0);
    chk("stl_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("stl_fwd_waddr", 32'(fwd_waddr), 32'd5);
    chk("stl_fwd_wdata", fwd_wdata, 32'hA4);
    chk("stl_rf_we",     32'(rf_we), 32'd0);
    chk("stl_retire",    retire_cnt, 32'd10);
    chk("stl_head",      debug_wb_pc, 32'h200);
    tick();
    chk("stl2_rf_we",    32'(rf_we), 32'd0);
    chk("stl2_head",     debug_wb_pc, 32'h200);
    chk("stl2_wdata",    debug_wb_rf_wdata, 32'hA0);
    chk("stl2_retire",   retire_cnt, 32'd10);
    debug_ready = 1'b1;
    #1 chk("rel_ready_go", 32'(wb_ready_go), 32'd1);
    chk("rel_rf_we",     32'(rf_we), 32'hF);
    chk("rel_waddr",     32'(rf_waddr), 32'd5);
    tick();

    // full FIFO with simultaneous push and pop every cycle; head trails WB by four
    for (int c = 7; c < 27; c++) begin
      drv(1'b1, 32'h200 + 32'(4 * (c - 1)), 4'hF, 5'(((c - 1) % 31) + 1), 32'hA0 + 32'(c - 1));
      #1 chk("wrap_head",  debug_wb_pc, 32'h200 + 32'(4 * (c - 6)));
      chk("wrap_rf_we",    32'(rf_we), 32'hF);
      chk("wrap_waddr",    32'(rf_waddr), 32'(((c - 2) % 31) + 1));
      chk("wrap_retire",   retire_cnt, 32'(c + 4));
      tick();
    end
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    debug_ready = 1'b0;
    #1 chk("wrap_full_ready_go", 32'(wb_ready_go), 32'd0);
    chk("wrap_full_allow_in", 32'(wb_allow_in), 32'd0);
    chk("wrap_full_rf_we",    32'(rf_we), 32'd0);
    chk("wrap_full_head",     debug_wb_pc, 32'h200 + 32'(4 * 21));
    chk("wrap_full_retire",   retire_cnt, 32'd31);
    debug_ready = 1'b1;
    tick();
    #1 chk("drain_head",  debug_wb_pc, 32'h200 + 32'(4 * 22));
    chk("drain_retire",  retire_cnt, 32'd32);
    tick();
    debug_ready = 1'b0;
    #1 chk("pre_rst_head", debug_wb_pc, 32'h200 + 32'(4 * 23));
    chk("pre_rst_dbgv",  32'(debug_valid), 32'd1);

    // asynchronous reset between edges with three entries pending
    drv(1'b1, 32'h2a0, 4'hF, 5'd9, 32'h99);
    #1 resetn = 1'b0;
    #1 chk("arst_dbgv",  32'(debug_valid), 32'd0);
    chk("arst_retire",   retire_cnt, 32'd0);
    chk("arst_rf_we",    32'(rf_we), 32'd0);
    chk("arst_fwd",      32'(fwd_valid), 32'd0);
    chk("arst_dbg_pc",   debug_wb_pc, 32'd0);
    chk("arst_rf_wdata", rf_wdata, 32'd0);
    tick();
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    resetn = 1'b1;
    debug_ready = 1'b1;
    tick();
    chk("post_rst_rf_we",  32'(rf_we), 32'd0);
    chk("post_rst_dbgv",   32'(debug_valid), 32'd0);
    chk("post_rst_retire", retire_cnt, 32'd0);
    drv(1'b1, 32'h300, 4'hF, 5'd7, 32'h77);
    tick();
    drv(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #1 chk("new_rf_we",  32'(rf_we), 32'hF);
    chk("new_waddr",     32'(rf_waddr), 32'd7);
    chk("new_retire",    retire_cnt, 32'd0);
    tick();
    chk("new_head",      debug_wb_pc, 32'h300);
    chk("new_retire2",   retire_cnt, 32'd1);
    chk("new_rf_we_off", 32'(rf_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_stage_trace.md
Name: wb_stage_trace

Overview:
- Parametrised write-back stage for the in-order LA32R pipeline. It registers the MEM->WB payload and commits the register-file write exactly once per instruction.
- Drives an ID-stage bypass port and pushes every retired instruction into a small trace FIFO read by the difftest/debug sink.
- WB stalls (ready_go=0) only when the trace FIFO cannot accept the retiring entry.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- PC_W, 32, program counter width.
- WE_W, 4, byte write-enable width (DATA_W/8).
- TRACE_DEPTH, 4, trace FIFO entries; power of two, >=2.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- to_wb_valid  in  1  MEM stage presents an instruction.
- in_pc  in  PC_W  instruction PC.
- in_rf_we  in  WE_W  byte write enables.
- in_rf_waddr  in  ADDR_W  destination register.
- in_rf_wdata  in  DATA_W  write data.
- wb_allow_in  out  1  WB can accept this cycle.
- wb_ready_go  out  1  held instruction may retire this cycle.
- rf_we  out  WE_W  register-file byte enables (commit-qualified).
- rf_waddr  out  ADDR_W  register-file address.
- rf_wdata  out  DATA_W  register-file data.
- fwd_valid  out  1  WB holds a valid instruction writing a nonzero register.
- fwd_waddr  out  ADDR_W  bypass address.
- fwd_wdata  out  DATA_W  bypass data.
- debug_valid  out  1  trace FIFO non-empty.
- debug_ready  in  1  sink pops the head entry.
- debug_wb_pc  out  PC_W  head entry PC.
- debug_wb_rf_we  out  WE_W  head entry byte enables (zeroed for r0).
- debug_wb_rf_wnum  out  ADDR_W  head entry register.
- debug_wb_rf_wdata  out  DATA_W  head entry data.
- retire_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset is asynchronous and active-low: wb_valid=0, payload regs=0, FIFO rd/wr ptrs=0, count=0, retire_cnt=0. All outputs therefore read 0 except wb_allow_in=1 and wb_ready_go=1.
- wb_ready_go = !fifo_full || debug_ready. A pop and a push in the same cycle at full are legal.
- wb_allow_in = !wb_valid || wb_ready_go.
- Payload load: when wb_allow_in is 1, wb_valid <= to_wb_valid. Payload regs load only if to_wb_valid=1; otherwise they hold.
- commit = wb_valid && wb_ready_go. Latency: an instruction accepted in cycle N commits in cycle N+1 at the earliest.
- RF write port:
  - rf_we = commit ? eff_we : 0.
  - eff_we = (waddr==0) ? 0 : payload we.
  - rf_waddr and rf_wdata come directly from the payload regs.
  - A stalled instruction never writes early, and never writes twice.
- Bypass: fwd_valid = wb_valid && |eff_we. It is independent of commit, so it stays valid during a stall.
- Trace FIFO:
  - Push on commit; every retired instruction is pushed, including we=0. Entry = {pc, eff_we, waddr, wdata}.
  - Pop when debug_valid && debug_ready.
  - Pointers are log2(TRACE_DEPTH)+1 bits and wrap modulo 2*TRACE_DEPTH. full = MSBs differ and low bits equal; empty = pointers equal.
  - Simultaneous push and pop at empty: the pushed entry appears at the head the next cycle. There is no fall-through, so debug_valid stays 0 that cycle.
  - Simultaneous push and pop at full: count is unchanged.
  - Head outputs hold stable while debug_valid=1 and debug_ready=0.
- retire_cnt increments by 1 per commit and wraps at 2^CNT_W.
- Reset asserted mid-stall: state clears immediately. Pending FIFO entries are lost, and no RF write occurs after reset is asserted.

Decomposition:
- Shared package:
  - wb_trace_t struct {pc, we, wnum, wdata}, sized by the parameters above.
  - Constant RF_ZERO_IDX = 0.
- One sub-module is natural: wb_trace_fifo. It is a synchronous FIFO (parametrised WIDTH, DEPTH) with push/pop/full/empty/head and no fall-through.

Test Plan:
- Reset release, debug_ready=1, three back-to-back instructions (pc 0x1c000000/04/08, waddr 1/2/3, we=0xF) -> one rf_we=0xF pulse per instruction in consecutive cycles; the trace shows three entries in order; retire_cnt=3.
- waddr=0, we=0xF, wdata=0xDEADBEEF -> rf_we=0, fwd_valid=0; trace entry has we=0, wnum=0; retire_cnt increments.
- debug_ready=0 with a stream of 6 instructions, TRACE_DEPTH=4 -> 4 commits. Then wb_ready_go=0 and wb_allow_in=0, and the 5th holds in WB with fwd_valid=1 and no rf_we. Raising debug_ready -> the 5th commits in the same cycle as the first pop.
- FIFO full plus push and pop in the same cycle over 20 cycles -> count stays 4; pointer wrap is exercised; no entry is lost or duplicated (compare against a scoreboard).
- resetn dropped asynchronously mid-stall (FIFO holding 3 entries) -> outputs clear before the next edge; debug_valid=0, retire_cnt=0, no rf_we after release until a new instruction arrives.
- to_wb_valid bubble between instructions -> no rf_we and no trace push for the bubble; the payload of the prior instruction is not re-committed.
